// File: rtl/gpio_frame_streamer_if.sv
// Word-addressed read bus between the frame streamer (master) and its source memory (slave).
// Read data is expected one cycle after the strobe.
interface gpio_frame_streamer_if;
   logic [17:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_rdata;

   modport master (output mem_addr, output mem_rd, input mem_rdata);
   modport slave  (input mem_addr, input mem_rd, output mem_rdata);
endinterface

// File: rtl/gpio_frame_streamer.sv
// Streams one frame of memory words out of an 8-bit GPIO port, LSB byte first,
// prefetching the next word during the last byte of the current one so the stream has no gaps.
module gpio_frame_streamer #(
   parameter int SECTOR_WORDS = 10000,
   parameter int LEN0_BYTES   = 40000,
   parameter int LEN1_BYTES   = 88804
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         selected,
   input  logic [3:0]                   sector_select,
   gpio_frame_streamer_if.master        mem,
   output logic [7:0]                   gpio,
   output logic                         gpio_valid,
   output logic                         busy,
   output logic                         done
);

   localparam logic [17:0] LAST_WORD0 = 18'(LEN0_BYTES / 4 - 1);
   localparam logic [17:0] LAST_WORD1 = 18'(LEN1_BYTES / 4 - 1);

   typedef enum logic [1:0] {IDLE, FETCH, STREAM, FINISH} state_t;

   state_t      state, state_next;
   logic        sel_q, sel_d;
   logic [17:0] addr_q, addr_d;
   logic [17:0] word_q, word_d;
   logic [1:0]  byte_q, byte_d;
   logic [23:0] hold_q, hold_d;
   logic [17:0] base_calc;
   logic        last_word;

   assign base_calc    = 18'(32'(sector_select) * 32'(SECTOR_WORDS));
   assign last_word    = (word_q == (sel_q ? LAST_WORD1 : LAST_WORD0));
   assign mem.mem_addr = addr_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         sel_q  <= 1'b0;
         addr_q <= '0;
         word_q <= '0;
         byte_q <= '0;
         hold_q <= '0;
      end else begin
         state  <= state_next;
         sel_q  <= sel_d;
         addr_q <= addr_d;
         word_q <= word_d;
         byte_q <= byte_d;
         hold_q <= hold_d;
      end
   end

   // Byte 0 comes straight off the read bus; bytes 1-3 come from the upper bits captured then.
   // The address advances one cycle early so the prefetch strobe sees it during byte 3.
   always_comb begin
      state_next  = state;
      sel_d       = sel_q;
      addr_d      = addr_q;
      word_d      = word_q;
      byte_d      = byte_q;
      hold_d      = hold_q;
      mem.mem_rd  = 1'b0;
      gpio        = 8'h00;
      gpio_valid  = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = FETCH;
               sel_d      = selected;
               addr_d     = base_calc;
               word_d     = '0;
               byte_d     = '0;
            end
         end
         FETCH: begin
            busy       = 1'b1;
            mem.mem_rd = 1'b1;
            state_next = STREAM;
         end
         STREAM: begin
            busy       = 1'b1;
            gpio_valid = 1'b1;
            byte_d     = byte_q + 2'd1;
            unique case (byte_q)
               2'd0: begin
                  gpio   = mem.mem_rdata[7:0];
                  hold_d = mem.mem_rdata[31:8];
               end
               2'd1: gpio = hold_q[7:0];
               2'd2: begin
                  gpio = hold_q[15:8];
                  if (!last_word) addr_d = addr_q + 18'd1;
               end
               2'd3: begin
                  gpio = hold_q[23:16];
                  if (last_word) begin
                     state_next = FINISH;
                  end else begin
                     mem.mem_rd = 1'b1;
                     word_d     = word_q + 18'd1;
                  end
               end
            endcase
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: doc/gpio_frame_streamer.md
GPIO_FRAME_STREAMER -- requirements
Module: gpio_frame_streamer

Interface
REQ-001 SHALL have parameter SECTOR_WORDS, default 10000, giving the word stride between sector base addresses.
REQ-002 SHALL have parameter LEN0_BYTES, default 40000, giving the frame length in bytes when selected=0.
REQ-003 SHALL have parameter LEN1_BYTES, default 88804, giving the frame length in bytes when selected=1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: request to stream one frame.
REQ-007 SHALL have port selected, input, 1 bit: algorithm select; chooses LEN0_BYTES or LEN1_BYTES.
REQ-008 SHALL have port sector_select, input, 4 bits: source sector index.
REQ-009 SHALL have port mem_rdata, input, 32 bits: read data, valid one cycle after mem_rd.
REQ-010 SHALL have port mem_addr, output, 18 bits: word address.
REQ-011 SHALL have port mem_rd, output, 1 bit: read strobe.
REQ-012 SHALL have port gpio, output, 8 bits: streamed byte.
REQ-013 SHALL have port gpio_valid, output, 1 bit: gpio carries a frame byte this cycle.
REQ-014 SHALL have port busy, output, 1 bit: frame in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-016 SHALL implement the states IDLE, FETCH, STREAM and FINISH.
REQ-017 IDLE SHALL transition to FETCH on the edge where start=1; on that edge it SHALL latch selected, sector_select and a base address of sector_select*SECTOR_WORDS.
REQ-018 The length and base SHALL come only from the latched copies; changes to selected or sector_select mid-frame SHALL have no effect.
REQ-019 FETCH (one cycle) SHALL assert mem_rd=1 with mem_addr=base, then transition to STREAM.
REQ-020 The first gpio_valid SHALL occur exactly 2 cycles after the start-sampling edge.
REQ-021 In STREAM, each 32-bit word SHALL emit 4 bytes on consecutive cycles, LSB first: bits [7:0], [15:8], [23:16], [31:24].
REQ-022 While the last byte of a word is on gpio and more words remain, the block SHALL assert mem_rd with mem_addr+1; the stream SHALL then run one byte per cycle with no gaps.
REQ-023 A frame SHALL contain exactly LEN bytes, with word count LEN/4 (LEN is a multiple of 4).
REQ-024 No read SHALL be issued past the last word.
REQ-025 mem_addr SHALL be 18-bit unsigned; base plus offset never exceeds 15*SECTOR_WORDS+LEN1_BYTES/4-1 and does not wrap.
REQ-026 After the final byte, the block SHALL enter FINISH for one cycle with done=1, gpio_valid=0 and busy=0, then return to IDLE.
REQ-027 busy SHALL be 1 in FETCH and STREAM, and 0 otherwise.
REQ-028 start asserted while busy=1 or in FINISH SHALL be ignored; it is not queued.
REQ-029 start held high continuously SHALL begin a new frame on the first IDLE edge after FINISH.
REQ-030 gpio SHALL be 8'h00 whenever gpio_valid=0.
REQ-031 mem_addr SHALL hold its last value when mem_rd=0.

Reset
REQ-032 When rst=0 at a clock edge, the block SHALL go to IDLE.
REQ-033 During reset, gpio=0, gpio_valid=0, busy=0, done=0, mem_rd=0 and mem_addr=0, and all latched fields and counters SHALL clear.
REQ-034 Reset mid-frame SHALL abort without a done pulse.
REQ-035 After rst returns to 1, no activity SHALL occur until a new start.

Verification
REQ-036 Bench SHALL cover: rst=0 held 3 cycles, then released -> all outputs 0, busy=0, done=0.
REQ-037 Bench SHALL cover: selected=0, sector_select=0, start pulse at edge T -> mem_rd at T+1 with addr 0; 40000 contiguous valid bytes from T+2; done at T+40002; 10000 reads total.
REQ-038 Bench SHALL cover: selected=1, sector_select=4'b1000 -> first addr 80000; 88804 bytes; last read at addr 102200; single done pulse.
REQ-039 Bench SHALL cover: memory word 32'hA1B2C3D4 -> gpio sequence D4, C3, B2, A1.
REQ-040 Bench SHALL cover: start re-pulsed and selected/sector toggled mid-frame -> frame length and addresses unchanged; no second frame until IDLE.
REQ-041 Bench SHALL cover: rst=0 at byte 1000 -> next cycle outputs 0 and no done; a subsequent start streams a full frame from base.
